// File: rtl/stopwatch_pkg.sv
// Shared types and helpers for the BCD stopwatch counter.
// Digit moduli alternate 10/6 starting from the seconds units.
package stopwatch_pkg;

    localparam int BCD_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } sw_state_t;

    function automatic int digit_mod(input int i);
        if ((i % 2) == 0) begin
            return 10;
        end else begin
            return 6;
        end
    endfunction

endpackage

// File: rtl/stopwatch_counter_mod_digit.sv
// Single BCD digit with modulus MOD: saturating preset, increment/decrement with wrap.
// The value is held in a flop; at_max/at_zero feed the carry/borrow chain.
module mod_digit
    import stopwatch_pkg::*;
#(
    parameter int MOD = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [BCD_W-1:0] load_val,
    output logic [BCD_W-1:0] value,
    output logic             at_max,
    output logic             at_zero
);

    localparam logic [BCD_W-1:0] MAX_V  = BCD_W'(MOD - 1);
    localparam logic [BCD_W-1:0] ZERO_V = BCD_W'(0);
    localparam logic [BCD_W-1:0] ONE_V  = BCD_W'(1);

    logic [BCD_W-1:0] value_r;
    logic [BCD_W-1:0] sat_s;
    logic [BCD_W-1:0] step_s;

    // Clamp out-of-range presets to the largest legal digit value
    always_comb begin
        sat_s = load_val;
        if (load_val > MAX_V) begin
            sat_s = MAX_V;
        end else begin
            sat_s = load_val;
        end
    end

    // Next count value: wrap to 0 going up, reload to MAX going down
    always_comb begin
        step_s = value_r;
        if (up) begin
            if (value_r == MAX_V) begin
                step_s = ZERO_V;
            end else begin
                step_s = value_r + ONE_V;
            end
        end else begin
            if (value_r == ZERO_V) begin
                step_s = MAX_V;
            end else begin
                step_s = value_r - ONE_V;
            end
        end
    end

    // Digit register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            value_r <= ZERO_V;
        end else if (load) begin
            value_r <= sat_s;
        end else if (en) begin
            value_r <= step_s;
        end else begin
            value_r <= value_r;
        end
    end

    assign value   = value_r;
    assign at_max  = (value_r == MAX_V);
    assign at_zero = (value_r == ZERO_V);

endmodule

// File: rtl/stopwatch_counter.sv
// Up/down BCD stopwatch: run/pause/clear FSM, preset load, wrap pulse and
// terminal-count stop in down mode over a chain of N_DIGITS mod_digit instances.
module stopwatch_counter
    import stopwatch_pkg::*;
#(
    parameter int N_DIGITS = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      tick,
    input  logic                      start,
    input  logic                      stop,
    input  logic                      clear,
    input  logic                      up,
    input  logic                      load,
    input  logic [BCD_W*N_DIGITS-1:0] load_value,
    output logic [BCD_W*N_DIGITS-1:0] digits,
    output logic                      running,
    output logic                      wrap,
    output logic                      done
);

    sw_state_t state_r;
    sw_state_t state_n;

    logic [N_DIGITS-1:0]       en_s;
    logic [N_DIGITS-1:0]       max_s;
    logic [N_DIGITS-1:0]       zero_s;
    logic [BCD_W*N_DIGITS-1:0] digits_s;
    logic [BCD_W*N_DIGITS-1:0] dload_val_s;
    logic                      dload_s;
    logic                      all_zero_s;
    logic                      all_max_s;
    logic                      near_zero_s;
    logic                      tick_s;
    logic                      tick_cnt_s;
    logic                      running_r;
    logic                      wrap_r;
    logic                      done_r;

    assign all_zero_s  = &zero_s;
    assign all_max_s   = &max_s;
    // Count is exactly 1: the next down tick lands on zero
    assign near_zero_s = (digits_s[BCD_W-1:0] == BCD_W'(1)) && (&(zero_s | N_DIGITS'(1)));

    // stop and clear both swallow a coincident tick
    assign tick_s      = (state_r == RUN) && tick && !clear && !stop;
    assign tick_cnt_s  = tick_s && (up || !all_zero_s);

    // clear reuses the preset path with an all-zero value
    assign dload_s     = clear || (load && ((state_r == IDLE) || (state_r == PAUSE)));
    assign dload_val_s = clear ? {(BCD_W*N_DIGITS){1'b0}} : load_value;

    for (genvar i = 0; i < N_DIGITS; i++) begin : g_digit
        if (i == 0) begin : g_lsd
            assign en_s[i] = tick_cnt_s;
        end else begin : g_upper
            assign en_s[i] = tick_cnt_s && (up ? (&max_s[i-1:0]) : (&zero_s[i-1:0]));
        end

        mod_digit #(
            .MOD (digit_mod(i))
        ) u_digit (
            .clk      (clk),
            .rst_n    (rst_n),
            .en       (en_s[i]),
            .up       (up),
            .load     (dload_s),
            .load_val (dload_val_s[BCD_W*i +: BCD_W]),
            .value    (digits_s[BCD_W*i +: BCD_W]),
            .at_max   (max_s[i]),
            .at_zero  (zero_s[i])
        );
    end

    // Next-state logic with clear > load > stop > start > tick priority
    always_comb begin
        state_n = state_r;
        if (clear) begin
            state_n = IDLE;
        end else begin
            case (state_r)
                IDLE, PAUSE: begin
                    if (load) begin
                        state_n = state_r;
                    end else if (start) begin
                        state_n = (!up && all_zero_s) ? DONE : RUN;
                    end else begin
                        state_n = state_r;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state_n = PAUSE;
                    end else if (tick && !up && (all_zero_s || near_zero_s)) begin
                        state_n = DONE;
                    end else begin
                        state_n = RUN;
                    end
                end
                DONE:    state_n = DONE;
                default: state_n = IDLE;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // Status flags registered from the next state so they align with digits
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            running_r <= 1'b0;
            done_r    <= 1'b0;
            wrap_r    <= 1'b0;
        end else begin
            running_r <= (state_n == RUN);
            done_r    <= (state_n == DONE);
            wrap_r    <= tick_s && up && all_max_s;
        end
    end

    assign digits  = digits_s;
    assign running = running_r;
    assign done    = done_r;
    assign wrap    = wrap_r;

endmodule
